chain_dp_sched: RTL and testbench
=================================

# chain_dp_sched

Sequencer for the anchor-chaining DP datapath. Accepts anchors one at a time and holds the last DEPTH anchors with their chain scores in a ring buffer. For each new anchor it issues every eligible (predecessor, current) pair into the fully pipelined gap-score unit (`computeScorepp`), one pair per cycle. It then collects the returning gap scores, keeps the best `f[j] + score`, and emits the anchor's chain score and best predecessor.

## Interface
- DEPTH, 64: ring-buffer entries; power of 2, > MAX_PRED.
- MAX_PRED, 16: max predecessors examined per anchor.
- SCORE_LAT, 12: fixed score-unit latency in cycles, issue to `sc_result`.
- MAX_DIST, 5000: max reference distance for an eligible pair.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- chain_start  in  1  pulse; begins a new read, anchor index := 0, aborts any work in progress.
- cfg_w_avg  in  32  average seed span; driven to `sc_W_avg`; static within a read.
- in_valid  in  1  anchor offered.
- in_ready  out  1  scheduler can accept an anchor.
- in_rx  in  32  anchor reference position.
- in_qy  in  32  anchor query position.
- in_w  in  32  anchor span; initial chain score.
- sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W  out  32 each  score-unit operands: r_j, r_i, q_j, q_i, w_i.
- sc_W_avg  out  32  equals `cfg_w_avg`.
- sc_result  in  32  signed gap score, valid exactly SCORE_LAT cycles after issue.
- out_valid  out  1  result held until accepted.
- out_ready  in  1  consumer accepts.
- out_f  out  32  signed chain score f[i].
- out_p  out  16  absolute index of the best predecessor.
- out_p_valid  out  1  0 = no predecessor; `out_f` = `in_w`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch the anchor, write (rx, qy) to ring slot `i mod DEPTH`.
  - Set `best_f` = `in_w`, `best_p` invalid, K = min(i, MAX_PRED), j = i-1.
  - Go to ISSUE if K > 0, else DRAIN.
- ISSUE:
  - One candidate j per cycle, j descending from i-1 to i-K.
  - Pair is eligible iff r_j < r_i, q_j < q_i, and r_i - r_j <= MAX_DIST (unsigned).
  - Eligible pair: drive operands, push tag (j, f[j]) into a SCORE_LAT-deep valid/tag delay line, increment in-flight count.
  - Ineligible pair: consumes its cycle, nothing issued.
  - After the last j, go to DRAIN.
- Result collection runs in any state:
  - When the delay line output is valid: cand = f[j] + `sc_result` (32-bit signed, wraps), decrement in-flight count.
  - If cand > `best_f` (strict), update `best_f`/`best_p`. Ties keep the earlier-returned pair, i.e. the nearer predecessor.
- DRAIN: go to OUTPUT when the in-flight count is 0 and no result returns this cycle.
- OUTPUT:
  - `out_valid` = 1; `out_f`/`out_p`/`out_p_valid` stable until `out_ready`.
  - On accept: write `best_f` into ring f[i mod DEPTH], i := i+1, go to IDLE.
- Operand ports hold their last value when no pair is issued; `sc_result` is ignored except at tagged cycles.
- Anchor index i is 16 bits and wraps at 65535; ring index is the low log2(DEPTH) bits.
- `chain_start`:
  - From any state: next state IDLE, i := 0, delay line cleared, in-flight count := 0, `out_valid` := 0.
  - Highest priority, above a simultaneous input or output handshake.

## Timing
- Reset values: `in_ready` 0 during reset, 1 in the first cycle after reset; `out_valid`, `out_f`, `out_p`, `out_p_valid` = 0; all `sc_*` = 0; i = 0.
- Anchor accepted at edge t, first ISSUE cycle at t+1.
- K = 0: DRAIN at t+1, `out_valid` at t+2.
- K > 0 with last eligible issue at cycle c: result sampled at c+SCORE_LAT, `out_valid` at c+SCORE_LAT+2.
- K > 0 with no eligible pair: `out_valid` 2 cycles after the last ISSUE cycle.
- Throughput: one pair per cycle in ISSUE; one anchor in flight at a time.
- Reset mid-operation: everything returns to reset values immediately; in-flight results are discarded.

## Test plan
- Reset, then anchor 0 (rx=100, qy=100, w=15) → `out_valid` 2 cycles after accept; f=15, `out_p_valid`=0; no `sc_*` issue.
- Stub score unit returns 7 after SCORE_LAT. Anchors (100,100,15) then (150,160,15) → second anchor: one issue with sc_riX=100, sc_riY=150; f=22, p=0; `out_valid` at issue+SCORE_LAT+2.
- 20 collinear anchors spaced 10 apart, w=15, stub=7 → anchor 19 issues exactly 16 pairs (j=18..3); f grows by 7 per anchor; p=i-1.
- Predecessor with r_j ≥ r_i, or r_i - r_j = 5001 → no issue for that j; r_i - r_j = 5000 → issued.
- Stub returns -100 for every pair → f = `in_w`, `out_p_valid`=0. Equal candidates → p is the nearest j.
- `chain_start` pulsed mid-ISSUE, with results in flight → next cycle IDLE, no `out_valid`; late `sc_result` ignored; next anchor gets index 0.

Source files
------------

// File: rtl/chain_dp_sched.sv
// Anchor-chaining DP sequencer: issues (predecessor, current) pairs to a pipelined
// gap-score unit, tracks the returning scores and emits the best chain score per anchor.
module chain_dp_sched #(
  parameter int          DEPTH     = 64,
  parameter int          MAX_PRED  = 16,
  parameter int          SCORE_LAT = 12,
  parameter logic [31:0] MAX_DIST  = 32'd5000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chain_start,
  input  logic [31:0]        cfg_w_avg,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_rx,
  input  logic [31:0]        in_qy,
  input  logic [31:0]        in_w,
  output logic [31:0]        sc_riX,
  output logic [31:0]        sc_riY,
  output logic [31:0]        sc_qiX,
  output logic [31:0]        sc_qiY,
  output logic [31:0]        sc_W,
  output logic [31:0]        sc_W_avg,
  input  logic signed [31:0] sc_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_f,
  output logic [15:0]        out_p,
  output logic               out_p_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int KW = $clog2(MAX_PRED + 1);
  localparam int IW = $clog2(MAX_PRED + SCORE_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;
  state_t state_q, state_d;

  logic [31:0]        rx_mem [DEPTH];
  logic [31:0]        qy_mem [DEPTH];
  logic signed [31:0] f_mem  [DEPTH];

  logic [15:0]        idx_q, j_q, best_p_q;
  logic [KW-1:0]      k_q, k_init;
  logic [IW-1:0]      inflight_q;
  logic [31:0]        cur_rx_q, cur_qy_q, cur_w_q, w_avg_q;
  logic signed [31:0] best_f_q;
  logic               best_pv_q;
  logic [31:0]        op_rj_q, op_ri_q, op_qj_q, op_qi_q, op_w_q;

  logic               dl_vld_q [SCORE_LAT];
  logic [15:0]        dl_j_q   [SCORE_LAT];
  logic signed [31:0] dl_f_q   [SCORE_LAT];

  logic [AW-1:0]      jslot, islot;
  logic [31:0]        rj, qj;
  logic signed [31:0] fj, cand;
  logic               elig, issue, accept_in, accept_out, ret_vld;

  assign jslot      = j_q[AW-1:0];
  assign islot      = idx_q[AW-1:0];
  assign rj         = rx_mem[jslot];
  assign qj         = qy_mem[jslot];
  assign fj         = f_mem[jslot];
  assign elig       = (rj < cur_rx_q) && (qj < cur_qy_q) && ((cur_rx_q - rj) <= MAX_DIST);
  assign issue      = (state_q == ISSUE) && elig;
  assign in_ready   = (state_q == IDLE) && !reset;
  assign accept_in  = in_valid && in_ready && !chain_start;
  assign accept_out = (state_q == OUTPUT) && out_ready && !chain_start;
  assign ret_vld    = dl_vld_q[SCORE_LAT-1];
  assign cand       = dl_f_q[SCORE_LAT-1] + sc_result;
  assign k_init     = (idx_q >= 16'(MAX_PRED)) ? KW'(MAX_PRED) : idx_q[KW-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_in) state_d = (k_init != '0) ? ISSUE : DRAIN;
      ISSUE:   if (k_q == KW'(1)) state_d = DRAIN;
      DRAIN:   if ((inflight_q == '0) && !ret_vld) state_d = OUTPUT;
      OUTPUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (chain_start) state_d = IDLE;
  end

  // Control: state, counters, valid delay line, best-so-far, held operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      inflight_q <= '0;
      best_f_q   <= '0;
      best_p_q   <= '0;
      best_pv_q  <= 1'b0;
      w_avg_q    <= '0;
      op_rj_q    <= '0;
      op_ri_q    <= '0;
      op_qj_q    <= '0;
      op_qi_q    <= '0;
      op_w_q     <= '0;
      for (int k = 0; k < SCORE_LAT; k++) dl_vld_q[k] <= 1'b0;
    end else if (chain_start) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      inflight_q <= '0;
      w_avg_q    <= cfg_w_avg;
      for (int k = 0; k < SCORE_LAT; k++) dl_vld_q[k] <= 1'b0;
    end else begin
      state_q <= state_d;
      w_avg_q <= cfg_w_avg;
      dl_vld_q[0] <= issue;
      for (int k = 1; k < SCORE_LAT; k++) dl_vld_q[k] <= dl_vld_q[k-1];
      if (issue && !ret_vld)      inflight_q <= inflight_q + IW'(1);
      else if (!issue && ret_vld) inflight_q <= inflight_q - IW'(1);
      if (accept_in) begin
        best_f_q  <= in_w;
        best_p_q  <= '0;
        best_pv_q <= 1'b0;
        k_q       <= k_init;
        j_q       <= idx_q - 16'd1;
      end else if (ret_vld && (cand > best_f_q)) begin
        // Strict compare: ties keep the earlier-returned, nearer predecessor
        best_f_q  <= cand;
        best_p_q  <= dl_j_q[SCORE_LAT-1];
        best_pv_q <= 1'b1;
      end
      if (state_q == ISSUE) begin
        k_q <= k_q - KW'(1);
        j_q <= j_q - 16'd1;
      end
      if (issue) begin
        op_rj_q <= rj;
        op_ri_q <= cur_rx_q;
        op_qj_q <= qj;
        op_qi_q <= cur_qy_q;
        op_w_q  <= cur_w_q;
      end
      if (accept_out) idx_q <= idx_q + 16'd1;
    end
  end

  // Data: ring buffer, current anchor, tag delay line
  always_ff @(posedge clk) begin
    if (accept_in) begin
      rx_mem[islot] <= in_rx;
      qy_mem[islot] <= in_qy;
      cur_rx_q      <= in_rx;
      cur_qy_q      <= in_qy;
      cur_w_q       <= in_w;
    end
    if (accept_out) f_mem[islot] <= best_f_q;
    dl_j_q[0] <= j_q;
    dl_f_q[0] <= fj;
    for (int k = 1; k < SCORE_LAT; k++) begin
      dl_j_q[k] <= dl_j_q[k-1];
      dl_f_q[k] <= dl_f_q[k-1];
    end
  end

  assign sc_riX      = issue ? rj       : op_rj_q;
  assign sc_riY      = issue ? cur_rx_q : op_ri_q;
  assign sc_qiX      = issue ? qj       : op_qj_q;
  assign sc_qiY      = issue ? cur_qy_q : op_qi_q;
  assign sc_W        = issue ? cur_w_q  : op_w_q;
  assign sc_W_avg    = w_avg_q;
  assign out_valid   = (state_q == OUTPUT);
  assign out_f       = best_f_q;
  assign out_p       = best_p_q;
  assign out_p_valid = best_pv_q;

endmodule

// File: tb/tb_chain_dp_sched.sv
// Scoreboard bench for chain_dp_sched with a constant-score stub of the gap-score unit.
module tb_chain_dp_sched;
  localparam int L = 12;

  logic               clk = 1'b0;
  logic               reset, chain_start, in_valid, in_ready, out_valid, out_ready, out_p_valid;
  logic [31:0]        cfg_w_avg, in_rx, in_qy, in_w;
  logic [31:0]        sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W, sc_W_avg;
  logic signed [31:0] sc_result, out_f;
  logic [15:0]        out_p;

  chain_dp_sched dut (
    .clk(clk), .reset(reset), .chain_start(chain_start), .cfg_w_avg(cfg_w_avg),
    .in_valid(in_valid), .in_ready(in_ready), .in_rx(in_rx), .in_qy(in_qy), .in_w(in_w),
    .sc_riX(sc_riX), .sc_riY(sc_riY), .sc_qiX(sc_qiX), .sc_qiY(sc_qiY), .sc_W(sc_W),
    .sc_W_avg(sc_W_avg), .sc_result(sc_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_p(out_p), .out_p_valid(out_p_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub score unit: fully pipelined, returns stub_val L cycles after the operands
  int stub_val = 7;
  logic signed [31:0] pipe [L];
  initial for (int k = 0; k < L; k++) pipe[k] = '0;
  always @(posedge clk) begin
    for (int k = L - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    pipe[0] <= stub_val;
  end
  assign sc_result = pipe[L-1];

  // Issue monitor: every issue presents a new operand tuple
  logic [127:0] prev_tup = '0;
  int iss_cnt = 0;
  always @(negedge clk) begin
    if ({sc_riX, sc_riY, sc_qiX, sc_qiY} !== prev_tup) iss_cnt = iss_cnt + 1;
    prev_tup = {sc_riX, sc_riY, sc_qiX, sc_qiY};
  end

  typedef struct {
    int f; int p; bit pv; int lat; int iss; bit has_op;
    logic [31:0] rj; logic [31:0] ri; logic [31:0] qj; logic [31:0] qi; logic [31:0] w;
  } exp_t;
  exp_t sbq[$];

  int unsigned m_rx [256];
  int unsigned m_qy [256];
  int          m_f  [256];
  int          mi = 0;
  int          cyc_acc = 0;
  int          n_run = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic drive_anchor(input int unsigned rx, input int unsigned qy, input int w);
    exp_t e;
    int k, last_off;
    e.f = w; e.p = 0; e.pv = 0; e.iss = 0; e.has_op = 0;
    e.rj = '0; e.ri = '0; e.qj = '0; e.qi = '0; e.w = '0;
    last_off = -1;
    k = (mi < 16) ? mi : 16;
    for (int off = 0; off < k; off++) begin
      int j;
      j = mi - 1 - off;
      if (m_rx[j] < rx && m_qy[j] < qy && (rx - m_rx[j]) <= 32'd5000) begin
        int cand;
        e.iss++;
        last_off = off;
        e.has_op = 1;
        e.rj = m_rx[j]; e.ri = rx; e.qj = m_qy[j]; e.qi = qy; e.w = w;
        cand = m_f[j] + stub_val;
        if (cand > e.f) begin e.f = cand; e.p = j; e.pv = 1; end
      end
    end
    if (k == 0) e.lat = 2;
    else if (e.iss > 0) e.lat = (last_off + L + 3 > k + 2) ? last_off + L + 3 : k + 2;
    else e.lat = k + 2;
    m_rx[mi] = rx; m_qy[mi] = qy; m_f[mi] = e.f; mi++;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b1; in_rx = rx; in_qy = qy; in_w = w;
    @(posedge clk);
    #1;
    cyc_acc = cyc;
    iss_cnt = 0;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    exp_t e;
    bit seen;
    seen = 0;
    e = sbq.pop_front();
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_lat"}, cyc - cyc_acc + 1, e.lat);
    check({tag, "_iss"}, iss_cnt, e.iss);
    if (e.has_op) begin
      check({tag, "_op"}, {sc_riX ^ sc_riY ^ sc_W}, {e.rj ^ e.ri ^ e.w});
      check({tag, "_opq"}, {sc_qiX ^ (sc_qiY << 1)}, {e.qj ^ (e.qi << 1)});
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == hold - 1) check({tag, "_hold"}, {31'd0, out_valid}, 32'd1);
    end
    check({tag, "_f"}, out_f, e.f);
    check({tag, "_pv"}, {31'd0, out_p_valid}, {31'd0, e.pv});
    if (e.pv) check({tag, "_p"}, {16'd0, out_p}, e.p);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_done"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic restart();
    @(negedge clk);
    chain_start = 1'b1;
    @(negedge clk);
    chain_start = 1'b0;
    mi = 0;
  endtask

  initial begin
    reset = 1'b1; chain_start = 1'b0; cfg_w_avg = 32'd0;
    in_valid = 1'b0; in_rx = '0; in_qy = '0; in_w = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sc", sc_riX | sc_riY | sc_qiX | sc_qiY | sc_W | sc_W_avg, 32'd0);
    reset = 1'b0;
    cfg_w_avg = 32'd15;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out", out_f | {15'd0, out_p, out_p_valid}, 32'd0);

    // First anchor and single predecessor
    drive_anchor(100, 100, 15);
    collect("a0", 0);
    drive_anchor(150, 160, 15);
    collect("a1", 3);
    check("w_avg", sc_W_avg, 32'd15);

    // Collinear chain: window limited to MAX_PRED predecessors
    restart();
    for (int i = 0; i < 20; i++) begin
      drive_anchor(100 + 10 * i, 100 + 10 * i, 15);
      collect($sformatf("col%0d", i), i % 3);
    end

    // Distance and ordering eligibility
    restart();
    drive_anchor(100, 100, 15);    collect("d0", 0);
    drive_anchor(5100, 200, 15);   collect("d5000", 0);
    drive_anchor(10101, 300, 15);  collect("d5001", 0);
    drive_anchor(50, 400, 15);     collect("dback", 0);

    // Negative scores never beat the anchor span
    restart();
    stub_val = -100;
    drive_anchor(100, 100, 15);    collect("n0", 0);
    drive_anchor(150, 160, 15);    collect("n1", 0);
    drive_anchor(200, 200, 20);    collect("n2", 0);

    // Equal candidates pick the nearest predecessor
    restart();
    stub_val = 0;
    drive_anchor(100, 100, 10);    collect("t0", 0);
    drive_anchor(200, 50, 10);     collect("t1", 0);
    drive_anchor(300, 300, 5);     collect("t2", 0);

    // Abort mid-ISSUE with results in flight
    restart();
    stub_val = 7;
    for (int i = 0; i < 4; i++) begin
      drive_anchor(10 + 10 * i, 10 + 10 * i, 15);
      collect($sformatf("ab%0d", i), 0);
    end
    drive_anchor(50, 50, 15);
    @(negedge clk);
    chain_start = 1'b1;
    @(negedge clk);
    chain_start = 1'b0;
    void'(sbq.pop_back());
    mi = 0;
    check("abort_idle", {31'd0, in_ready}, 32'd1);
    check("abort_no_out", {31'd0, out_valid}, 32'd0);
    drive_anchor(100, 100, 15);
    collect("after_abort", 16);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end
endmodule
